// File: rtl/imem_loader_if.sv
// Byte-stream load channel for the instruction-memory boot loader.
// The master drives program bytes and the slave (the loader) returns ld_ready.
interface imem_loader_if;
  logic       ld_valid;
  logic [7:0] ld_byte;
  logic       ld_last;
  logic       ld_ready;

  modport master (output ld_valid, output ld_byte, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_byte, input ld_last, output ld_ready);
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with boot loader: packs a byte stream into 16-bit words,
// holds the CPU in reset until loading completes, then serves IR = mem[PC].
module imem_loader #(
  parameter int          ADDR_W      = 8,
  parameter int          HOLD_CYCLES = 2,
  parameter logic [15:0] NOP_WORD    = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  imem_loader_if.slave      ld,
  input  logic [ADDR_W-1:0] PC,
  output logic [15:0]       IR,
  output logic              cpu_reset,
  output logic              loading,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]   WC_MAX    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_TOP  = '1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       mem [DEPTH];
  logic [DEPTH-1:0]  vld_bits;
  logic [ADDR_W-1:0] wr_addr;
  logic              phase_lo;
  logic [7:0]        hi_byte;
  logic [HC_W-1:0]   hold_cnt;

  logic              accept;
  logic              wr_en;
  logic [15:0]       wr_data;

  // Acceptance is derived from state directly so ld_ready never feeds back into itself.
  assign accept  = ld.ld_valid && (state == S_LOAD);
  assign wr_en   = accept && (phase_lo || ld.ld_last);
  assign wr_data = phase_lo ? {hi_byte, ld.ld_byte} : {ld.ld_byte, 8'h00};

  always_comb begin
    state_nxt   = state;
    ld.ld_ready = 1'b0;
    loading     = 1'b0;
    cpu_reset   = 1'b1;
    unique case (state)
      S_LOAD: begin
        ld.ld_ready = 1'b1;
        loading     = 1'b1;
        if (ld.ld_valid && ld.ld_last) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        if (reload) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_LOAD;
      wr_addr    <= '0;
      phase_lo   <= 1'b0;
      hold_cnt   <= '0;
      overflow   <= 1'b0;
      word_count <= '0;
      vld_bits   <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;
      if (state == S_RUN && reload) begin
        wr_addr    <= '0;
        phase_lo   <= 1'b0;
        overflow   <= 1'b0;
        word_count <= '0;
        vld_bits   <= '0;
      end
      if (accept) begin
        if (wr_en) begin
          vld_bits[wr_addr] <= 1'b1;
          wr_addr           <= wr_addr + 1'b1;
          phase_lo          <= 1'b0;
          if (word_count != WC_MAX) word_count <= word_count + 1'b1;
          // Wrapping past the top only counts as overflow when more program follows.
          if (wr_addr == ADDR_TOP && !ld.ld_last) overflow <= 1'b1;
        end else begin
          phase_lo <= 1'b1;
        end
      end
    end
  end

  // Data path: no reset, but an asserted reset still blocks the write.
  always_ff @(posedge clk) begin
    if (reset && accept && !phase_lo) hi_byte <= ld.ld_byte;
    if (reset && wr_en) mem[wr_addr] <= wr_data;
  end

  assign IR = vld_bits[PC] ? mem[PC] : NOP_WORD;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: program bytes are turned into expected memory
// contents by a word-level model and compared against IR over the whole address space.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int          ADDR_W = 8;
  localparam int          HOLD   = 2;
  localparam int          DEPTH  = 256;
  localparam logic [15:0] NOP    = 16'h0000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              reload = 1'b0;
  logic [ADDR_W-1:0] PC = '0;
  logic [15:0]       IR;
  logic              cpu_reset;
  logic              loading;
  logic              overflow;
  logic [ADDR_W:0]   word_count;

  imem_loader_if ld_if ();

  imem_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .reload     (reload),
    .ld         (ld_if.slave),
    .PC         (PC),
    .IR         (IR),
    .cpu_reset  (cpu_reset),
    .loading    (loading),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mem_m [DEPTH];
  bit          valid_m [DEPTH];
  int          m_wc;
  bit          m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) valid_m[i] = 1'b0;
    m_wc  = 0;
    m_ovf = 1'b0;
  endfunction

  // Whole-program view: word k is bytes 2k,2k+1 (odd tail padded with 00), stored at k mod DEPTH.
  function automatic void model_load(input logic [7:0] b[$]);
    int n, nw;
    n  = b.size();
    nw = (n + 1) / 2;
    for (int k = 0; k < nw; k++) begin
      mem_m[k % DEPTH]   = (2 * k + 1 < n) ? {b[2 * k], b[2 * k + 1]} : {b[2 * k], 8'h00};
      valid_m[k % DEPTH] = 1'b1;
    end
    m_wc  = (nw > DEPTH) ? DEPTH : nw;
    m_ovf = (nw > DEPTH);
  endfunction

  task automatic send_program(input logic [7:0] b[$], input int gap_mode, input int rl_at);
    int          n, idle;
    logic [15:0] w;
    n = b.size();
    for (int i = 0; i < n; i++) begin
      idle = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
      if (i == rl_at) begin
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
      end
      repeat (idle) @(negedge clk);
      check("ld_ready", ld_if.ld_ready, 1);
      ld_if.ld_valid = 1'b1;
      ld_if.ld_byte  = b[i];
      ld_if.ld_last  = (i == n - 1);
      @(negedge clk);
      ld_if.ld_valid = 1'b0;
      ld_if.ld_last  = 1'b0;
      if ((i % 2 == 1) || (i == n - 1)) begin
        w  = (i % 2 == 1) ? {b[i - 1], b[i]} : {b[i], 8'h00};
        PC = ADDR_W'((i / 2) % DEPTH);
        #1;
        check("ir_next", IR, w);
      end
    end
  endtask

  task automatic check_hold(input bit pulse_reload);
    for (int c = 0; c < HOLD; c++) begin
      check("hold_cpu_reset", cpu_reset, 1);
      check("hold_loading", loading, 0);
      check("hold_ready", ld_if.ld_ready, 0);
      if (c == 0 && pulse_reload) reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      #1;
    end
    check("run_cpu_reset", cpu_reset, 0);
    check("run_loading", loading, 0);
    check("run_ready", ld_if.ld_ready, 0);
  endtask

  task automatic check_counts();
    check("word_count", word_count, m_wc);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic sweep(input string tag);
    for (int p = 0; p < DEPTH; p++) begin
      @(negedge clk);
      PC = ADDR_W'(p);
      #1;
      check(tag, IR, valid_m[p] ? mem_m[p] : NOP);
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    model_clear();
    #1;
    check("reload_loading", loading, 1);
    check("reload_cpu_reset", cpu_reset, 1);
    check_counts();
  endtask

  initial begin
    logic [7:0] q[$];
    int         n;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_byte  = '0;
    ld_if.ld_last  = 1'b0;
    model_clear();

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ready", ld_if.ld_ready, 1);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_loading", loading, 1);
    check_counts();
    sweep("ir_reset");

    // Single word program
    q = '{8'h98, 8'h45};
    send_program(q, 0, -1);
    model_load(q);
    check_counts();
    check_hold(0);
    PC = '0;
    #1;
    check("ir_9845", IR, 16'h9845);
    sweep("ir_one_word");

    // Three words, valid 1-of-3 cycles, reload ignored in LOAD and HOLD
    do_reload();
    sweep("ir_after_reload");
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    send_program(q, 1, 2);
    model_load(q);
    check_counts();
    check_hold(1);
    sweep("ir_three_words");

    // 257 words: wrap and overwrite
    do_reload();
    q.delete();
    for (int i = 0; i < 514; i++) q.push_back(8'($urandom));
    send_program(q, 0, -1);
    model_load(q);
    check_counts();
    check_hold(0);
    sweep("ir_wrap");

    // ld_last on a HI byte
    do_reload();
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    q.push_back(8'hE0);
    send_program(q, 2, -1);
    model_load(q);
    check_counts();
    check_hold(0);
    sweep("ir_hi_last");

    // Reset after a single HI byte, then reset colliding with a handshake
    do_reload();
    @(negedge clk);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_byte  = 8'hAB;
    @(negedge clk);
    ld_if.ld_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    #1;
    check("midload_loading", loading, 1);
    check_counts();
    @(negedge clk);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_byte  = 8'hCD;
    ld_if.ld_last  = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
    reset = 1'b1;
    #1;
    check("collide_loading", loading, 1);
    check("collide_cpu_reset", cpu_reset, 1);
    check_counts();
    sweep("ir_after_reset");
    q = '{8'h11, 8'h22};
    send_program(q, 0, -1);
    model_load(q);
    check_counts();
    check_hold(0);
    sweep("ir_fresh_phase");

    // Random programs
    repeat (4) begin
      do_reload();
      q.delete();
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      send_program(q, 2, -1);
      model_load(q);
      check_counts();
      check_hold(0);
      sweep("ir_random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
